mem_axi_master: RTL and testbench

MEM_AXI_MASTER -- requirements
Module: mem_axi_master

---
 rtl/config.sv | 4 +
 rtl/cpu_axi_pkg.sv | 27 ++
 rtl/mem_axi_master.sv | 165 ++++++++++++++++
 tb/tb_mem_axi_master.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/config.sv
// Core-wide build configuration shared by the CPU memory subsystem.
package cpu_config;
   localparam int CPU_WIDTH = 64;
endpackage

// File: rtl/cpu_axi_pkg.sv
// Shared AXI4 encodings and the memory-master FSM state type.
package cpu_axi_pkg;
   import cpu_config::*;

   localparam int STRB_W = CPU_WIDTH / 8;

   typedef enum logic [2:0] {
      IDLE,
      WR_REQ,
      WR_RESP,
      RD_REQ,
      RD_DATA,
      DONE
   } state_t;

   localparam logic [1:0] BURST_INCR  = 2'b01;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_EXOKAY = 2'b01;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   localparam logic [1:0] SIZE_B = 2'b00;
   localparam logic [1:0] SIZE_H = 2'b01;
   localparam logic [1:0] SIZE_W = 2'b10;
   localparam logic [1:0] SIZE_D = 2'b11;
endpackage

// File: rtl/mem_axi_master.sv
// Single-beat AXI4 master: turns one CPU load/store request at a time into
// an AR/R or AW/W/B exchange and returns aligned read data plus the response.
module mem_axi_master
   import cpu_config::*;
   import cpu_axi_pkg::*;
#(
   parameter logic [3:0] AXI_ID = 4'h1,
   parameter int         ADDR_W = 64
) (
   input  logic                 i_clk,
   input  logic                 i_rst,

   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic                 req_wen,
   input  logic [ADDR_W-1:0]    req_addr,
   input  logic [1:0]           req_size,
   input  logic [CPU_WIDTH-1:0] req_wdata,
   input  logic [STRB_W-1:0]    req_wmask,
   output logic [CPU_WIDTH-1:0] rsp_rdata,
   output logic [1:0]           rsp_resp,

   output logic                 awvalid,
   input  logic                 awready,
   output logic [ADDR_W-1:0]    awaddr,
   output logic [3:0]           awid,
   output logic [7:0]           awlen,
   output logic [2:0]           awsize,
   output logic [1:0]           awburst,

   output logic                 wvalid,
   input  logic                 wready,
   output logic [CPU_WIDTH-1:0] wdata,
   output logic [STRB_W-1:0]    wstrb,
   output logic                 wlast,

   input  logic                 bvalid,
   output logic                 bready,
   input  logic [1:0]           bresp,

   output logic                 arvalid,
   input  logic                 arready,
   output logic [ADDR_W-1:0]    araddr,
   output logic [3:0]           arid,
   output logic [7:0]           arlen,
   output logic [2:0]           arsize,
   output logic [1:0]           arburst,

   input  logic                 rvalid,
   output logic                 rready,
   input  logic [CPU_WIDTH-1:0] rdata,
   input  logic [1:0]           rresp,
   input  logic                 rlast
);

   state_t                 state, state_nxt;
   logic [ADDR_W-1:0]      addr_q;
   logic [1:0]             size_q;
   logic [CPU_WIDTH-1:0]   wdata_q;
   logic [STRB_W-1:0]      wmask_q;
   logic                   aw_done, w_done;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) state <= IDLE;
      else       state <= state_nxt;
   end

   // Valids and readies decode straight from state, so reset clears them in the same cycle.
   always_comb begin
      // NOTE: every output gets a default first so no path through the case infers a latch.
      state_nxt = state;
      awvalid   = 1'b0;
      wvalid    = 1'b0;
      bready    = 1'b0;
      arvalid   = 1'b0;
      rready    = 1'b0;
      req_ready = 1'b0;
      case (state)
         IDLE: begin
            if (req_valid) state_nxt = req_wen ? WR_REQ : RD_REQ;
         end
         WR_REQ: begin
            awvalid = !aw_done;
            wvalid  = !w_done;
            if ((aw_done || awready) && (w_done || wready)) state_nxt = WR_RESP;
         end
         WR_RESP: begin
            bready = 1'b1;
            if (bvalid) state_nxt = DONE;
         end
         RD_REQ: begin
            arvalid = 1'b1;
            if (arready) state_nxt = RD_DATA;
         end
         RD_DATA: begin
            rready = 1'b1;
            if (rvalid && rlast) state_nxt = DONE;
         end
         DONE: begin
            req_ready = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         addr_q    <= '0;
         size_q    <= '0;
         wdata_q   <= '0;
         wmask_q   <= '0;
         aw_done   <= 1'b0;
         w_done    <= 1'b0;
         rsp_rdata <= '0;
         rsp_resp  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  addr_q  <= req_addr;
                  size_q  <= req_size;
                  wdata_q <= req_wdata;
                  wmask_q <= req_wmask;
                  aw_done <= 1'b0;
                  w_done  <= 1'b0;
               end
            end
            WR_REQ: begin
               if (awvalid && awready) aw_done <= 1'b1;
               if (wvalid && wready)   w_done  <= 1'b1;
            end
            WR_RESP: begin
               if (bvalid) begin
                  rsp_resp  <= bresp;
                  rsp_rdata <= '0;
               end
            end
            RD_DATA: begin
               // Bring the addressed byte lane down to bit 0.
               if (rvalid && rlast) begin
                  rsp_resp  <= rresp;
                  rsp_rdata <= rdata >> {addr_q[2:0], 3'b000};
               end
            end
            default: ;
         endcase
      end
   end

   assign awid    = AXI_ID;
   assign arid    = AXI_ID;
   assign awlen   = 8'd0;
   assign arlen   = 8'd0;
   assign awburst = BURST_INCR;
   assign arburst = BURST_INCR;
   assign awsize  = {1'b0, size_q};
   assign arsize  = {1'b0, size_q};
   assign awaddr  = addr_q;
   assign araddr  = addr_q;
   assign wdata   = wdata_q;
   assign wstrb   = wmask_q;
   assign wlast   = 1'b1;

endmodule

// File: tb/tb_mem_axi_master.sv
// Directed bench for mem_axi_master: a scoreboard queue holds the expected
// response of each request and a negedge monitor compares it when req_ready rises.
module tb_mem_axi_master;

   logic        i_clk, i_rst;
   logic        req_valid, req_ready, req_wen;
   logic [63:0] req_addr;
   logic [1:0]  req_size;
   logic [63:0] req_wdata;
   logic [7:0]  req_wmask;
   logic [63:0] rsp_rdata;
   logic [1:0]  rsp_resp;
   logic        awvalid, awready;
   logic [63:0] awaddr;
   logic [3:0]  awid;
   logic [7:0]  awlen;
   logic [2:0]  awsize;
   logic [1:0]  awburst;
   logic        wvalid, wready;
   logic [63:0] wdata;
   logic [7:0]  wstrb;
   logic        wlast;
   logic        bvalid, bready;
   logic [1:0]  bresp;
   logic        arvalid, arready;
   logic [63:0] araddr;
   logic [3:0]  arid;
   logic [7:0]  arlen;
   logic [2:0]  arsize;
   logic [1:0]  arburst;
   logic        rvalid, rready;
   logic [63:0] rdata;
   logic [1:0]  rresp;
   logic        rlast;

   int tests = 0;
   int fails = 0;
   int aw_hs = 0;
   int w_hs  = 0;

   logic [63:0] exp_rdata_q[$];
   logic [1:0]  exp_resp_q[$];

   mem_axi_master #(.AXI_ID(4'h1), .ADDR_W(64)) dut (
      .i_clk(i_clk), .i_rst(i_rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
      .req_addr(req_addr), .req_size(req_size), .req_wdata(req_wdata),
      .req_wmask(req_wmask), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
      .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awid(awid),
      .awlen(awlen), .awsize(awsize), .awburst(awburst),
      .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
      .bvalid(bvalid), .bready(bready), .bresp(bresp),
      .arvalid(arvalid), .arready(arready), .araddr(araddr), .arid(arid),
      .arlen(arlen), .arsize(arsize), .arburst(arburst),
      .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp), .rlast(rlast)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   initial begin
      #200000;
      $display("FAIL global timeout: bench did not finish, got running expected done");
      $fatal(1, "timeout");
   end

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   always @(posedge i_clk) begin
      if (awvalid && awready) aw_hs <= aw_hs + 1;
      if (wvalid && wready)   w_hs  <= w_hs + 1;
   end

   // Scoreboard monitor: every req_ready pulse must match the oldest expectation.
   always @(negedge i_clk) begin
      if (req_ready === 1'b1) begin
         if (exp_rdata_q.size() == 0) begin
            check("unexpected rsp", 64'(req_ready), 64'd0);
         end else begin
            check("rsp_rdata", rsp_rdata, exp_rdata_q.pop_front());
            check("rsp_resp", 64'(rsp_resp), 64'(exp_resp_q.pop_front()));
         end
      end
   end

   task automatic tick;
      @(posedge i_clk);
      #1;
   endtask

   localparam int ARV = 0, RR = 1, BR = 2, REQR = 3, AWV = 4;

   function automatic logic sig_of(input int which);
      case (which)
         ARV:     return arvalid;
         RR:      return rready;
         BR:      return bready;
         REQR:    return req_ready;
         default: return awvalid;
      endcase
   endfunction

   task automatic wait_for(input int which, input string name);
      int n = 0;
      while (sig_of(which) !== 1'b1 && n < 32) begin
         tick();
         n++;
      end
      check({name, " seen"}, 64'(sig_of(which)), 64'd1);
   endtask

   task automatic ar_phase(input logic [63:0] addr, input logic [1:0] size, input int delay);
      logic stable = 1'b1;
      wait_for(ARV, "arvalid");
      check("araddr", araddr, addr);
      check("arsize", 64'(arsize), 64'({1'b0, size}));
      check("arid/arlen/arburst", 64'({arid, arlen, arburst}), 64'({4'h1, 8'h00, 2'b01}));
      for (int c = 0; c < delay; c++) begin
         tick();
         if (arvalid !== 1'b1 || araddr !== addr) stable = 1'b0;
      end
      check("arvalid stable under arready=0", 64'(stable), 64'd1);
      arready = 1'b1;
      tick();
      arready = 1'b0;
      check("arvalid dropped after handshake", 64'(arvalid), 64'd0);
   endtask

   task automatic r_phase(input logic [63:0] rd, input logic [1:0] rr);
      wait_for(RR, "rready");
      rvalid = 1'b1; rdata = rd; rresp = rr; rlast = 1'b1;
      tick();
      rvalid = 1'b0; rlast = 1'b0;
   endtask

   task automatic finish_txn;
      wait_for(REQR, "req_ready");
      tick();
      check("req_ready one cycle", 64'(req_ready), 64'd0);
   endtask

   task automatic do_load(input logic [63:0] addr, input logic [1:0] size,
                          input logic [63:0] rd, input logic [1:0] rr,
                          input logic [63:0] exp, input int ar_delay);
      exp_rdata_q.push_back(exp);
      exp_resp_q.push_back(rr);
      req_valid = 1'b1; req_wen = 1'b0; req_addr = addr; req_size = size;
      tick();
      req_valid = 1'b0;
      ar_phase(addr, size, ar_delay);
      r_phase(rd, rr);
      finish_txn();
   endtask

   task automatic do_store(input logic [63:0] addr, input logic [1:0] size,
                           input logic [63:0] wd, input logic [7:0] wm,
                           input logic [1:0] br, input int aw_d, input int w_d);
      int aw0, w0;
      int last = (aw_d > w_d) ? aw_d : w_d;
      exp_rdata_q.push_back(64'd0);
      exp_resp_q.push_back(br);
      req_valid = 1'b1; req_wen = 1'b1; req_addr = addr; req_size = size;
      req_wdata = wd; req_wmask = wm;
      tick();
      req_valid = 1'b0;
      wait_for(AWV, "awvalid");
      check("awvalid+wvalid together", 64'({awvalid, wvalid}), 64'(2'b11));
      check("awaddr", awaddr, addr);
      check("awsize", 64'(awsize), 64'({1'b0, size}));
      check("wdata", wdata, wd);
      check("wstrb/wlast", 64'({wstrb, wlast}), 64'({wm, 1'b1}));
      check("awid/awlen/awburst", 64'({awid, awlen, awburst}), 64'({4'h1, 8'h00, 2'b01}));
      aw0 = aw_hs;
      w0  = w_hs;
      for (int c = 0; c <= last; c++) begin
         awready = (c == aw_d);
         wready  = (c == w_d);
         tick();
         if (c == w_d && c < aw_d) begin
            check("wvalid dropped, awvalid held", 64'({wvalid, awvalid}), 64'(2'b01));
         end
      end
      awready = 1'b0;
      wready  = 1'b0;
      wait_for(BR, "bready");
      check("aw/w valids low in WR_RESP", 64'({awvalid, wvalid}), 64'd0);
      bvalid = 1'b1; bresp = br;
      tick();
      bvalid = 1'b0;
      finish_txn();
      check("single AW handshake", 64'(aw_hs - aw0), 64'd1);
      check("single W handshake", 64'(w_hs - w0), 64'd1);
   endtask

   initial begin
      i_rst = 1'b1;
      req_valid = 0; req_wen = 0; req_addr = 0; req_size = 0; req_wdata = 0; req_wmask = 0;
      awready = 0; wready = 0; bvalid = 0; bresp = 0; arready = 0;
      rvalid = 0; rdata = 0; rresp = 0; rlast = 0;
      tick();
      tick();
      check("reset valids/readies",
            64'({req_ready, awvalid, wvalid, bready, arvalid, rready}), 64'd0);
      check("reset rsp", 64'({rsp_resp, rsp_rdata[61:0]}) | 64'(rsp_rdata[63:62]), 64'd0);
      i_rst = 1'b0;
      tick();

      // Aligned doubleword load, then byte load from lane 3.
      do_load(64'h8000_0008, 2'b11, 64'h1122_3344_5566_7788, 2'b00, 64'h1122_3344_5566_7788, 0);
      do_load(64'h8000_0003, 2'b00, 64'h0000_0000_AB00_0000, 2'b00, 64'h0000_0000_0000_00AB, 2);

      // Word store: W accepted first, AW three cycles later.
      do_store(64'h8000_0004, 2'b10, 64'hCAFE_F00D_0000_0000, 8'hF0, 2'b00, 3, 0);
      // Doubleword store with both handshakes in one cycle and an SLVERR response.
      do_store(64'h8000_0010, 2'b11, 64'h0123_4567_89AB_CDEF, 8'hFF, 2'b10, 0, 0);

      // Word load from upper lane with DECERR; a stray bvalid must be ignored.
      bvalid = 1'b1; bresp = 2'b10;
      do_load(64'h8000_0104, 2'b10, 64'h89AB_CDEF_0123_4567, 2'b11, 64'h0000_0000_89AB_CDEF, 1);
      check("bready low during load", 64'(bready), 64'd0);
      bvalid = 1'b0; bresp = 2'b00;

      // Reset while waiting in RD_DATA.
      req_valid = 1'b1; req_wen = 1'b0; req_addr = 64'h8000_0040; req_size = 2'b11;
      tick();
      req_valid = 1'b0;
      ar_phase(64'h8000_0040, 2'b11, 0);
      wait_for(RR, "rready before reset");
      i_rst = 1'b1;
      #1;
      check("reset mid-txn valids",
            64'({arvalid, rready, req_ready, awvalid, wvalid, bready}), 64'd0);
      check("reset mid-txn rsp_rdata", rsp_rdata, 64'd0);
      check("reset mid-txn rsp_resp", 64'(rsp_resp), 64'd0);
      check("constant id/len/burst in reset",
            64'({arid, arlen, arburst, awid, awlen, awburst}),
            64'({4'h1, 8'h00, 2'b01, 4'h1, 8'h00, 2'b01}));
      tick();
      i_rst = 1'b0;
      tick();
      rvalid = 1'b1; rdata = 64'hFFFF_FFFF_FFFF_FFFF; rresp = 2'b11; rlast = 1'b1;
      for (int c = 0; c < 3; c++) begin
         tick();
         check("late rvalid ignored", 64'({rready, req_ready}), 64'd0);
      end
      rvalid = 1'b0; rlast = 1'b0;
      check("rsp_rdata untouched by late rvalid", rsp_rdata, 64'd0);

      // Back-to-back: req_valid stays high across DONE.
      exp_rdata_q.push_back(64'h0102_0304_0506_0708);
      exp_resp_q.push_back(2'b00);
      exp_rdata_q.push_back(64'h0000_0000_0000_BEEF);
      exp_resp_q.push_back(2'b00);
      req_valid = 1'b1; req_wen = 1'b0; req_addr = 64'h8000_0020; req_size = 2'b11;
      tick();
      ar_phase(64'h8000_0020, 2'b11, 0);
      r_phase(64'h0102_0304_0506_0708, 2'b00);
      wait_for(REQR, "req_ready first b2b");
      req_addr = 64'h8000_0036; req_size = 2'b01;
      tick();
      check("idle after DONE: no arvalid", 64'({arvalid, req_ready}), 64'd0);
      tick();
      req_valid = 1'b0;
      ar_phase(64'h8000_0036, 2'b01, 5);
      r_phase(64'hBEEF_0000_0000_0000, 2'b00);
      finish_txn();

      tick();
      tick();
      check("scoreboard drained", 64'(exp_rdata_q.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
